// File: rtl/axi4_bram_slave.sv
// AXI4 slave over a word-addressed dual-port RAM; independent read and write FSMs.
// Optional AXI_MEM_OOR_ERR_EN: out-of-range addresses return SLVERR instead of aliasing.
module axi4_bram_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LSB);
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic cfg_err(input logic [2:0] sz, input logic [7:0] ln,
                                     input logic [1:0] bt);
        logic wrap_ok;
        wrap_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
        cfg_err = (sz > MAX_SIZE) || (bt == 2'b11) || (bt == 2'b10 && !wrap_ok);
    endfunction

    // Burst type arrives pre-sanitised: erroneous bursts are stored as FIXED.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] sz,
                                                    input logic [7:0] ln,
                                                    input logic [1:0] bt);
        logic [ADDR_W-1:0] incr, bound, base;
        incr  = ADDR_W'(1) << sz;
        bound = incr * (ADDR_W'(ln) + ADDR_W'(1));
        base  = a & ~(bound - ADDR_W'(1));
        case (bt)
            2'b01:   next_addr = (a & ~(incr - ADDR_W'(1))) + incr;
            2'b10:   next_addr = base + ((a + incr - base) & (bound - ADDR_W'(1)));
            default: next_addr = a;
        endcase
    endfunction

    logic alive;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [ADDR_W-1:0] w_addr, r_addr;
    logic [7:0]        w_len, w_cnt, r_len, r_cnt;
    logic [2:0]        w_size, r_size;
    logic [1:0]        w_burst, r_burst;
    logic              w_err, r_err, w_oor, r_oor;
    logic [IDX_W-1:0]  w_idx, r_idx;

    logic aw_hs, w_hs, ar_hs, r_hs, w_last_beat, r_last_beat;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign w_last_beat = (w_cnt == w_len);
    assign r_last_beat = (r_cnt == r_len);
    assign w_idx       = w_addr[LSB +: IDX_W];
    assign r_idx       = r_addr[LSB +: IDX_W];

`ifdef AXI_MEM_OOR_ERR_EN
    assign w_oor = |(w_addr >> (LSB + IDX_W));
    assign r_oor = |(r_addr >> (LSB + IDX_W));
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            alive   <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            alive   <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        unique case (w_state)
            W_IDLE: begin
                awready = alive;
                if (awvalid && alive) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = w_err ? SLVERR : 2'b00;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = alive;
                if (arvalid && alive) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = r_last_beat;
                if (rready) r_next = r_last_beat ? R_IDLE : R_FETCH;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= cfg_err(awsize, awlen, awburst) ? 2'b00 : awburst;
            w_cnt   <= '0;
            w_err   <= cfg_err(awsize, awlen, awburst);
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_err  <= w_err | (wlast != w_last_beat) | w_oor;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // rdata/rresp only load in FETCH, so they stay put while a beat is stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            if (ar_hs) begin
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= cfg_err(arsize, arlen, arburst) ? 2'b00 : arburst;
                r_cnt   <= '0;
                r_err   <= cfg_err(arsize, arlen, arburst);
            end
            if (r_state == R_FETCH) begin
                rdata <= r_oor ? '0 : mem[r_idx];
                rresp <= (r_err || r_oor) ? SLVERR : 2'b00;
            end
            if (r_hs && !r_last_beat) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
            end
        end
    end
endmodule

// File: tb/tb_axi4_bram_slave.sv
// Randomised and directed bench for axi4_bram_slave against a closed-form burst model.
// Expected OOR behaviour follows AXI_MEM_OOR_ERR_EN, as for the design.
module tb_axi4_bram_slave;
    localparam int DEP = 1024;
`ifdef AXI_MEM_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic aclk, aresetn;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;

    axi4_bram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEP)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] mdl [DEP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit burst_err(input logic [2:0] sz, input logic [7:0] len,
                                     input logic [1:0] bt);
        bit wrap_ok;
        wrap_ok = (len + 1 == 2) || (len + 1 == 4) || (len + 1 == 8) || (len + 1 == 16);
        return (sz > 2) || (bt == 3) || (bt == 2 && !wrap_ok);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] s, input logic [2:0] sz,
                                              input logic [7:0] len, input logic [1:0] bt,
                                              input int i);
        longint incr, bound, base, st, r;
        if (burst_err(sz, len, bt) || bt == 0) return s;
        st = longint'(s);
        incr = longint'(1) << sz;
        if (bt == 1) begin
            if (i == 0) return s;
            r = (st / incr) * incr + i * incr;
        end else begin
            bound = (longint'(len) + 1) * incr;
            base = (st / bound) * bound;
            r = base + ((st - base) + i * incr) % bound;
        end
        return r[31:0];
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return OOR_EN && ((a >> 12) != 0);
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [31:0] dq[$],
                            input logic [3:0] sq[$], input int bad_last, input string tag);
        bit err;
        int k;
        logic [31:0] ba;
        err = burst_err(sz, len, bt) || (bad_last >= 0);
        awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!awready && k < 200) begin @(negedge aclk); k++; end
        if (k >= 200) begin chk({tag, " aw timeout"}, awready, 1); awvalid = 1'b0; return; end
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(0, 1)) @(posedge aclk);
            #1;
            wdata = dq[i]; wstrb = sq[i];
            wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            wvalid = 1'b1;
            k = 0;
            @(negedge aclk);
            while (!wready && k < 200) begin @(negedge aclk); k++; end
            if (k >= 200) begin chk({tag, " w timeout"}, wready, 1); wvalid = 1'b0; return; end
            @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0;
            ba = beat_addr(a, sz, len, bt, i);
            if (oor(ba)) err = 1'b1;
            else for (int b = 0; b < 4; b++)
                if (sq[i][b]) mdl[ba[11:2]][8*b +: 8] = dq[i][8*b +: 8];
        end
        repeat ($urandom_range(0, 2)) @(posedge aclk);
        #1 bready = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!bvalid && k < 200) begin @(negedge aclk); k++; end
        chk({tag, " bresp"}, {bvalid, bresp}, {1'b1, err ? 2'b10 : 2'b00});
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input int stall_at, input int rst_at,
                           input string tag, output logic [31:0] got[$]);
        int k;
        logic [31:0] ba, d, ed;
        logic [1:0] rs;
        logic rl;
        bit eo;
        got = {};
        araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!arready && k < 200) begin @(negedge aclk); k++; end
        if (k >= 200) begin chk({tag, " ar timeout"}, arready, 1); arvalid = 1'b0; return; end
        @(posedge aclk); #1 arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            k = 0;
            @(negedge aclk);
            while (!rvalid && k < 200) begin @(negedge aclk); k++; end
            if (k >= 200) begin chk($sformatf("%s r%0d timeout", tag, i), rvalid, 1); return; end
            d = rdata; rs = rresp; rl = rlast;
            got.push_back(d);
            ba = beat_addr(a, sz, len, bt, i);
            eo = oor(ba);
            ed = eo ? 32'h0 : mdl[ba[11:2]];
            chk($sformatf("%s r%0d data", tag, i), d, ed);
            chk($sformatf("%s r%0d resp/last", tag, i), {rs, rl},
                {(burst_err(sz, len, bt) || eo) ? 2'b10 : 2'b00, i == int'(len)});
            if (i == rst_at) begin
                aresetn = 1'b0;
                #1 chk({tag, " rvalid in reset"}, {rvalid, rdata}, 33'h0);
                repeat (2) @(negedge aclk);
                aresetn = 1'b1;
                #1 chk({tag, " ready before edge"}, {awready, arready}, 2'b00);
                @(posedge aclk);
                #1 chk({tag, " ready after edge"}, {awready, arready}, 2'b11);
                return;
            end
            if (i == stall_at) begin
                repeat (5) begin
                    @(negedge aclk);
                    chk({tag, " stall hold"}, {rvalid, rlast, rresp, rdata}, {1'b1, rl, rs, d});
                end
            end else begin
                repeat ($urandom_range(0, 1)) @(negedge aclk);
            end
            rready = 1'b1;
            @(posedge aclk); #1 rready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] dq[$], got[$];
    logic [3:0]  sq[$];
    logic [31:0] wexp[4];

    initial begin
        logic [31:0] a;
        logic [7:0] len;
        logic [2:0] sz;
        logic [1:0] bt;
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset outputs", {awready, wready, bvalid, bresp, arready, rvalid, rlast, rresp},
            10'h0);
        chk("reset rdata", rdata, 32'h0);
        @(negedge aclk) aresetn = 1'b1;
        #1 chk("awready pre-edge", {awready, arready}, 2'b00);
        @(posedge aclk);
        #1 chk("ready post-edge", {awready, arready}, 2'b11);

        for (int blk = 0; blk < 4; blk++) begin
            dq = {}; sq = {};
            for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
            do_write(32'(blk * 1024), 8'd255, 3'd2, 2'b01, dq, sq, -1, "fill");
        end

        dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h10, 8'd3, 3'd2, 2'b01, dq, sq, -1, "incr wr");
        do_read(32'h10, 8'd3, 3'd2, 2'b01, -1, -1, "incr rd", got);
        for (int i = 0; i < 4; i++) chk("incr data", got[i], 32'(i + 1));

        do_read(32'h18, 8'd3, 3'd2, 2'b10, -1, -1, "wrap rd", got);
        wexp = '{32'd3, 32'd4, 32'd1, 32'd2};
        for (int i = 0; i < 4; i++) chk("wrap order", got[i], wexp[i]);
        do_read(32'h18, 8'd2, 3'd2, 2'b10, -1, -1, "wrap len2", got);

        dq = {32'hAABBCCDD}; sq = {4'hF};
        do_write(32'h0, 8'd0, 3'd2, 2'b01, dq, sq, -1, "full wr");
        dq = {32'h00001100}; sq = {4'b0010};
        do_write(32'h0, 8'd0, 3'd2, 2'b01, dq, sq, -1, "strb wr");
        do_read(32'h0, 8'd0, 3'd2, 2'b01, -1, -1, "strb rd", got);
        chk("strb merge", got[0], 32'hAABB11DD);

        dq = {32'h11111111, 32'h22222222}; sq = {4'hF, 4'h3};
        do_write(32'h40, 8'd1, 3'd3, 2'b01, dq, sq, -1, "size3 wr");
        do_read(32'h40, 8'd0, 3'd2, 2'b01, -1, -1, "size3 rd", got);

        do_read(32'h200, 8'd7, 3'd2, 2'b01, 3, -1, "stall rd", got);

        dq = {32'hA, 32'hB, 32'hC, 32'hD}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h80, 8'd3, 3'd2, 2'b01, dq, sq, 1, "wlast err");
        do_read(32'h80, 8'd3, 3'd2, 2'b01, -1, -1, "wlast rd", got);

        do_read(32'h100, 8'd7, 3'd2, 2'b01, -1, 2, "rst rd", got);
        do_read(32'h100, 8'd7, 3'd2, 2'b01, -1, -1, "post rst rd", got);

        dq = {32'h12345678}; sq = {4'hF};
        do_write(32'h1000, 8'd0, 3'd2, 2'b01, dq, sq, -1, "oor wr");
        do_read(32'h0, 8'd0, 3'd2, 2'b01, -1, -1, "oor word0", got);
        do_read(32'h1000, 8'd0, 3'd2, 2'b01, -1, -1, "oor rd", got);

        for (int t = 0; t < 25; t++) begin
            bt = 2'($urandom_range(0, 3));
            sz = 3'($urandom_range(0, 3));
            len = (bt == 2'b10 && $urandom_range(0, 3) != 0)
                ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
            a = 32'($urandom_range(0, 32'h1FFF));
            if (bt == 2'b10) a = a & ~((32'd1 << sz) - 1);
            dq = {}; sq = {};
            for (int i = 0; i <= int'(len); i++) begin
                dq.push_back($urandom); sq.push_back(4'($urandom_range(0, 15)));
            end
            do_write(a, len, sz, bt, dq, sq, -1, $sformatf("rnd%0d wr", t));
            do_read(a, len, sz, bt, (t % 7 == 3) ? 0 : -1, -1, $sformatf("rnd%0d rd", t), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
